ble_frame_rx: RTL and testbench
===============================

BLE_FRAME_RX -- requirements
Module: ble_frame_rx

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 10: number of 8-bit payload fields per frame, range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000: maximum idle clock cycles between bytes inside a frame, minimum 2.
REQ-003 SHALL have parameter ERR_CNT_W, default 16: width of the error counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: `clk` input, 1 bit; `rst_n` input, 1 bit.
REQ-005 SHALL have ports:
- `rx_byte` input, 8 bits: received UART byte.
- `rx_valid` input, 1 bit: one-cycle strobe, `rx_byte` valid.
- `fields` output, NUM_FIELDS x 8 bits: last accepted payload; field 0 is the first payload byte.
- `frame_valid` output, 1 bit: one-cycle pulse when `fields` updates.
- `cksum_err` output, 1 bit: one-cycle pulse on a checksum mismatch.
- `len_err` output, 1 bit: one-cycle pulse when the LEN byte is not NUM_FIELDS.
- `timeout_err` output, 1 bit: one-cycle pulse on an inter-byte timeout.
- `err_count` output, ERR_CNT_W bits: saturating total of all errors.
- `busy` output, 1 bit: high when the state is not IDLE.

Function
REQ-006 The frame format SHALL be: SOF byte 0xA5, then LEN byte, then LEN payload bytes, then CKSUM byte.
REQ-007 CKSUM SHALL be the XOR of the LEN byte and all payload bytes.
REQ-008 The FSM SHALL have states IDLE, GET_LEN, GET_PAYLOAD, GET_CKSUM; each transition occurs only on a cycle with `rx_valid` high, except on timeout.
REQ-009 In IDLE, 0xA5 SHALL move the FSM to GET_LEN; any other byte SHALL be discarded silently with no error.
REQ-010 In GET_LEN, LEN == NUM_FIELDS SHALL clear the index and the running XOR, then move to GET_PAYLOAD; any other LEN, including 0, SHALL pulse `len_err` and return to IDLE.
REQ-011 In GET_PAYLOAD, each byte SHALL be written to shadow buffer[index], folded into the XOR, and the index incremented; after byte NUM_FIELDS-1 the FSM SHALL move to GET_CKSUM.
REQ-012 In GET_PAYLOAD, the value 0xA5 SHALL be treated as ordinary data; there is no resync inside a frame.
REQ-013 In GET_CKSUM, a match SHALL copy the whole shadow buffer to `fields` and pulse `frame_valid` on the following cycle; a mismatch SHALL pulse `cksum_err`, leave `fields` unchanged, and return to IDLE.
REQ-014 `fields` SHALL only change atomically on an accepted frame; a partial or bad frame SHALL never alter any field.
REQ-015 An inter-byte timer SHALL clear on every `rx_valid` and count while not in IDLE.
REQ-016 When the timer reaches TIMEOUT_CYC-1, the block SHALL pulse `timeout_err` and return to IDLE.
REQ-017 If `rx_valid` coincides with timer expiry, the byte SHALL take priority and no timeout SHALL occur.
REQ-018 `err_count` SHALL increment by 1 per error pulse and saturate at its all-ones value; error pulses are mutually exclusive, so the count never increments by more than 1 per cycle.
REQ-019 Latency from the CKSUM byte strobe to `frame_valid` SHALL be exactly 1 cycle.
REQ-020 A new SOF SHALL be accepted in the cycle immediately after frame completion, so back-to-back frames are supported.

Reset
REQ-021 While `rst_n` is low, the block SHALL be in IDLE with all of the following cleared to 0: `fields`, shadow buffer, index, XOR, timer, `err_count`, and every pulse output; `busy` SHALL be 0.
REQ-022 A reset asserted mid-frame SHALL discard the frame; after release, the block SHALL require a fresh SOF.

Configuration
REQ-023 Macro BLE_FRAME_CKSUM_EN defined: the CKSUM byte is present and checked as in REQ-013.
REQ-024 BLE_FRAME_CKSUM_EN undefined: the GET_CKSUM state and the XOR logic SHALL be absent; after the last payload byte the frame SHALL be accepted directly, with `frame_valid` 1 cycle after that byte; `cksum_err` SHALL be tied to 0.

Structure
REQ-025 Package `ble_pkg` SHALL hold the FSM state enum, the SOF constant 0xA5, and a `field_t` typedef of 8 bits.
REQ-026 There SHALL be one sub-module, `ble_gap_timer`, containing the inter-byte counter with clear and enable inputs and an expire output; everything else stays in `ble_frame_rx`.

Verification
REQ-027 Good frame (CKSUM_EN on, NUM_FIELDS=10): A5,0A,01..0A,CKSUM=0A^01^..^0A=0x01 -> `frame_valid` for 1 cycle, `fields[0]`=01 and `fields[9]`=0A, `err_count`=0.
REQ-028 Bad checksum: same frame with CKSUM=0x55 -> `cksum_err` for 1 cycle, `fields` unchanged from prior value, `err_count`=1.
REQ-029 Wrong length: A5,03 -> `len_err` pulse; the following valid frame is accepted normally.
REQ-030 Timeout: A5,0A,11 then no byte for TIMEOUT_CYC cycles -> `timeout_err` pulse and `busy`=0; a byte landing on the expiry cycle instead -> no timeout.
REQ-031 Reset mid-payload: drop `rst_n` after the 5th payload byte -> all outputs 0; the next complete frame is accepted.
REQ-032 Saturation with ERR_CNT_W=2: 5 `len_err` frames -> `err_count` stays at 3.

Source files
------------

// File: rtl/ble_pkg.sv
// ble_pkg -- shared types and constants for the BLE frame receiver.
//   field_t : one 8-bit payload field
//   state_t : receiver FSM state encoding
//   SOF     : start-of-frame marker byte
package ble_pkg;

  typedef logic [7:0] field_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GET_LEN     = 2'd1,
    ST_GET_PAYLOAD = 2'd2,
    ST_GET_CKSUM   = 2'd3   // only reachable when the checksum byte is enabled
  } state_t;

  localparam field_t SOF = 8'hA5;

endpackage

// File: rtl/ble_gap_timer.sv
// ble_gap_timer -- inter-byte gap counter.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   i_clr    : restart the count (a byte arrived)
//   i_en     : count while a frame is in progress
//   o_expire : combinational, high on the cycle the gap reaches TIMEOUT_CYC
//              idle cycles; suppressed when i_clr is high so an arriving byte
//              always wins over expiry.
module ble_gap_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_expire  = i_en && !i_clr && w_at_last;

  // The count restarts on a byte, when disabled, and after an expiry so the
  // next frame always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ble_frame_rx.sv
// ble_frame_rx -- receives SOF(0xA5), LEN, LEN payload bytes [, CKSUM] from a
// UART byte stream and publishes the payload atomically on acceptance.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_byte, rx_valid     : received byte and its one-cycle strobe
//   fields                : last accepted payload, field 0 = first byte
//   frame_valid           : one-cycle pulse when fields updates
//   cksum_err/len_err/timeout_err : one-cycle error pulses
//   err_count             : saturating count of all error pulses
//   busy                  : FSM not in IDLE
// Build option: define BLE_FRAME_CKSUM_EN to include the trailing CKSUM byte
// (XOR of LEN and all payload bytes). Without it the frame is accepted on the
// last payload byte and cksum_err is tied low.
module ble_frame_rx
  import ble_pkg::*;
#(
  parameter int NUM_FIELDS  = 10,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_valid,
  output field_t [NUM_FIELDS-1:0]       fields,
  output logic                          frame_valid,
  output logic                          cksum_err,
  output logic                          len_err,
  output logic                          timeout_err,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic                          busy
);

  localparam field_t     LEN_BYTE = field_t'(NUM_FIELDS);
  localparam logic [7:0] LAST_IDX = 8'(NUM_FIELDS - 1);

  state_t               r_state;
  logic [7:0]           r_idx;
  field_t               r_shadow [NUM_FIELDS];
  field_t               r_fields [NUM_FIELDS];
  logic                 r_frame_valid;
  logic                 r_len_err;
  logic                 r_timeout_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic w_expire;
  logic w_len_ok;
  logic w_len_bad;
  logic w_pay_wr;
  logic w_last;
  logic w_accept;
  logic w_err_evt;

  assign w_len_ok  = (rx_byte == LEN_BYTE);
  assign w_len_bad = rx_valid && (r_state == ST_GET_LEN) && !w_len_ok;
  assign w_pay_wr  = rx_valid && (r_state == ST_GET_PAYLOAD);
  assign w_last    = (r_idx == LAST_IDX);

  ble_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (rx_valid),
    .i_en     (r_state != ST_IDLE),
    .o_expire (w_expire)
  );

`ifdef BLE_FRAME_CKSUM_EN
  field_t r_xor;
  logic   r_cksum_err;
  logic   w_cksum_bad;

  // The running XOR starts at zero after LEN, so LEN (a constant here) is
  // folded in at the comparison instead.
  assign w_accept    = rx_valid && (r_state == ST_GET_CKSUM) && (rx_byte == (r_xor ^ LEN_BYTE));
  assign w_cksum_bad = rx_valid && (r_state == ST_GET_CKSUM) && (rx_byte != (r_xor ^ LEN_BYTE));
  assign w_err_evt   = w_expire || w_len_bad || w_cksum_bad;
  assign cksum_err   = r_cksum_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor       <= '0;
      r_cksum_err <= 1'b0;
    end else begin
      r_cksum_err <= w_cksum_bad;
      if (rx_valid && (r_state == ST_GET_LEN) && w_len_ok) begin
        r_xor <= '0;
      end else if (w_pay_wr) begin
        r_xor <= r_xor ^ rx_byte;
      end
    end
  end
`else
  assign w_accept  = w_pay_wr && w_last;
  assign w_err_evt = w_expire || w_len_bad;
  assign cksum_err = 1'b0;
`endif

  // Control FSM, pulse outputs and the saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_frame_valid <= 1'b0;
      r_len_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_frame_valid <= w_accept;
      r_len_err     <= w_len_bad;
      r_timeout_err <= w_expire;
      if (w_err_evt && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end

      // Expiry never coincides with rx_valid (the timer suppresses it).
      if (w_expire) begin
        r_state <= ST_IDLE;
      end else if (rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (rx_byte == SOF) r_state <= ST_GET_LEN;
          end
          ST_GET_LEN: begin
            if (w_len_ok) begin
              r_idx   <= '0;
              r_state <= ST_GET_PAYLOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_GET_PAYLOAD: begin
            // 0xA5 is plain data here: no resync inside a frame.
            r_idx <= r_idx + 8'd1;
            if (w_last) begin
`ifdef BLE_FRAME_CKSUM_EN
              r_state <= ST_GET_CKSUM;
`else
              r_state <= ST_IDLE;
`endif
            end
          end
`ifdef BLE_FRAME_CKSUM_EN
          ST_GET_CKSUM: begin
            r_state <= ST_IDLE;
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Shadow buffer collects the frame; fields copy it only on acceptance so a
  // partial or bad frame can never disturb the published payload.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow[gi] <= '0;
          r_fields[gi] <= '0;
        end else begin
          if (w_pay_wr && (r_idx == 8'(gi))) begin
            r_shadow[gi] <= rx_byte;
          end
          if (w_accept) begin
`ifdef BLE_FRAME_CKSUM_EN
            r_fields[gi] <= r_shadow[gi];
`else
            // The last payload byte is still on rx_byte at acceptance.
            r_fields[gi] <= (gi == NUM_FIELDS - 1) ? rx_byte : r_shadow[gi];
`endif
          end
        end
      end
    end
  endgenerate

  always_comb begin
    fields = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      fields[i] = r_fields[i];
    end
  end

  assign frame_valid = r_frame_valid;
  assign len_err     = r_len_err;
  assign timeout_err = r_timeout_err;
  assign err_count   = r_err_cnt;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ble_frame_rx.sv
// tb_ble_frame_rx -- directed, table-driven bench for ble_frame_rx, plus
// hand-written sequences for timeout, byte-on-expiry, mid-frame reset and
// error-counter saturation. Works with or without BLE_FRAME_CKSUM_EN.
module tb_ble_frame_rx;

  localparam int NF = 10;
  localparam int TO = 20;
  localparam int EW = 2;
`ifdef BLE_FRAME_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic [NF-1:0][7:0]   fields;
  logic                 frame_valid;
  logic                 cksum_err;
  logic                 len_err;
  logic                 timeout_err;
  logic [EW-1:0]        err_count;
  logic                 busy;

  ble_frame_rx #(
    .NUM_FIELDS  (NF),
    .TIMEOUT_CYC (TO),
    .ERR_CNT_W   (EW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .fields      (fields),
    .frame_valid (frame_valid),
    .cksum_err   (cksum_err),
    .len_err     (len_err),
    .timeout_err (timeout_err),
    .err_count   (err_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    logic [7:0] seed;
    bit         corrupt;
    bit         exp_fv;
    bit         exp_ce;
    bit         exp_le;
  } vec_t;

  vec_t       vecs [6];
  int         n_checks;
  int         n_errors;
  int         exp_err;
  logic [7:0] exp_fields [NF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic bump_err();
    if (exp_err < (1 << EW) - 1) exp_err++;
  endtask

  // Sends SOF, LEN and, for a correct LEN, the payload seed+i and checksum.
  task automatic send_frame(input logic [7:0] len, input logic [7:0] seed, input bit corrupt);
    logic [7:0] x;
    send_byte(8'hA5);
    send_byte(len);
    if (len == 8'(NF)) begin
      x = len;
      for (int i = 0; i < NF; i++) begin
        send_byte(seed + 8'(i));
        x = x ^ (seed + 8'(i));
      end
      if (CK) send_byte(corrupt ? 8'h55 : x);
    end
  endtask

  task automatic check_fields(input string tag);
    for (int i = 0; i < NF; i += NF - 1) begin
      check($sformatf("%s_fields%0d", tag, i), {24'd0, fields[i]}, {24'd0, exp_fields[i]});
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_err  = 0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < NF; i++) exp_fields[i] = 8'h00;

    vecs[0] = '{8'h0A, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h0A, 8'h20, 1'b1, !CK,  CK,   1'b0};
    vecs[2] = '{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h0A, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h0A, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_frame_valid", {31'd0, frame_valid}, 0);
    check("rst_cksum_err",   {31'd0, cksum_err}, 0);
    check("rst_len_err",     {31'd0, len_err}, 0);
    check("rst_timeout_err", {31'd0, timeout_err}, 0);
    check("rst_err_count",   {30'd0, err_count}, 0);
    check("rst_busy",        {31'd0, busy}, 0);
    check("rst_fields_nz",   {31'd0, |fields}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-SOF byte in IDLE is silently dropped
    send_byte(8'h33);
    check("idle_junk_busy", {31'd0, busy}, 0);
    check("idle_junk_err",  {30'd0, err_count}, 0);
    $display("txn idle_junk byte=33 busy=%0d err_count=%0d", busy, err_count);

    // Table of back-to-back frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].len, vecs[v].seed, vecs[v].corrupt);
      if (vecs[v].exp_ce || vecs[v].exp_le) bump_err();
      if (vecs[v].exp_fv) begin
        for (int i = 0; i < NF; i++) exp_fields[i] = vecs[v].seed + 8'(i);
      end
      check($sformatf("v%0d_frame_valid", v), {31'd0, frame_valid}, {31'd0, vecs[v].exp_fv});
      check($sformatf("v%0d_cksum_err", v),   {31'd0, cksum_err},   {31'd0, vecs[v].exp_ce});
      check($sformatf("v%0d_len_err", v),     {31'd0, len_err},     {31'd0, vecs[v].exp_le});
      check($sformatf("v%0d_err_count", v),   {30'd0, err_count},   exp_err);
      check($sformatf("v%0d_busy", v),        {31'd0, busy}, 0);
      check_fields($sformatf("v%0d", v));
      $display("txn vec%0d len=%02h seed=%02h fv=%0d ce=%0d le=%0d err_count=%0d",
               v, vecs[v].len, vecs[v].seed, frame_valid, cksum_err, len_err, err_count);
    end
    @(negedge clk);
    check("pulse_width_fv", {31'd0, frame_valid}, 0);

    // Timeout after A5,0A,11
    send_frame_head();
    repeat (TO - 1) @(negedge clk);
    check("to_pre_timeout", {31'd0, timeout_err}, 0);
    check("to_pre_busy",    {31'd0, busy}, 1);
    @(negedge clk);
    bump_err();
    check("to_timeout",   {31'd0, timeout_err}, 1);
    check("to_busy",      {31'd0, busy}, 0);
    check("to_err_count", {30'd0, err_count}, exp_err);
    @(negedge clk);
    check("to_pulse_width", {31'd0, timeout_err}, 0);
    check_fields("to");
    $display("txn timeout busy=%0d err_count=%0d", busy, err_count);

    // Byte landing exactly on the expiry cycle wins
    begin
      logic [7:0] x;
      send_frame_head();
      x = 8'h0A ^ 8'h11;
      repeat (TO - 1) @(negedge clk);
      for (int i = 1; i < NF; i++) begin
        send_byte(8'h11 + 8'(i));
        x = x ^ (8'h11 + 8'(i));
        if (i == 1) begin
          check("edge_no_timeout", {31'd0, timeout_err}, 0);
          check("edge_busy",       {31'd0, busy}, 1);
        end
      end
      if (CK) send_byte(x);
      for (int i = 0; i < NF; i++) exp_fields[i] = 8'h11 + 8'(i);
      check("edge_frame_valid", {31'd0, frame_valid}, 1);
      check("edge_err_count",   {30'd0, err_count}, exp_err);
      check_fields("edge");
      $display("txn expiry_edge fv=%0d err_count=%0d", frame_valid, err_count);
    end

    // Reset in the middle of the payload
    send_byte(8'hA5);
    send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
    rst_n = 1'b0;
    #1;
    exp_err = 0;
    for (int i = 0; i < NF; i++) exp_fields[i] = 8'h00;
    check("mrst_fields_nz", {31'd0, |fields}, 0);
    check("mrst_busy",      {31'd0, busy}, 0);
    check("mrst_err_count", {30'd0, err_count}, 0);
    check("mrst_pulses",    {28'd0, frame_valid, cksum_err, len_err, timeout_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 5; i < NF; i++) send_byte(8'h40 + 8'(i));
    send_byte(8'h00);
    check("mrst_tail_fv",   {31'd0, frame_valid}, 0);
    check("mrst_tail_busy", {31'd0, busy}, 0);
    send_frame(8'h0A, 8'h50, 1'b0);
    for (int i = 0; i < NF; i++) exp_fields[i] = 8'h50 + 8'(i);
    check("mrst_next_fv", {31'd0, frame_valid}, 1);
    check_fields("mrst_next");
    $display("txn reset_mid_frame next_fv=%0d field0=%02h", frame_valid, fields[0]);

    // Error counter saturation
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h03, 8'h00, 1'b0);
      bump_err();
      check($sformatf("sat%0d_len_err", k),   {31'd0, len_err}, 1);
      check($sformatf("sat%0d_err_count", k), {30'd0, err_count}, exp_err);
      $display("txn sat%0d len_err=%0d err_count=%0d", k, len_err, err_count);
    end
    check("sat_final", {30'd0, err_count}, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic send_frame_head();
    send_byte(8'hA5);
    send_byte(8'h0A);
    send_byte(8'h11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
